image_frame_loader: RTL and testbench



---
 rtl/tpu_pkg.sv | 22 ++
 rtl/frame_watchdog.sv | 41 ++++
 rtl/image_frame_loader.sv | 125 ++++++++++++
 tb/tb_image_frame_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// ============================================================================
// Module : tpu_pkg
// Shared constants and types for the digit-recognition TPU datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

    localparam int IMG_DIM    = 32;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } loader_state_e;

    typedef logic [3:0] digit_t;

endpackage

`default_nettype wire

// File: rtl/frame_watchdog.sv
// ============================================================================
// Module : frame_watchdog
// Load/clear/count cycle counter that flags expiry at LIMIT-1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module frame_watchdog #(
    parameter int WIDTH = 17,
    parameter int LIMIT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_i,
    input  logic             cnt_en_i,
    output logic             expired_o
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (cnt_en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/image_frame_loader.sv
// ============================================================================
// Module : image_frame_loader
// Binarises a pixel stream into a frame, runs the TPU controller, captures digit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module image_frame_loader #(
    parameter int IMG_DIM = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic                           clk,
    input  logic                           iRst,
    input  logic [7:0]                     pix_data,
    input  logic                           pix_valid,
    input  logic                           pix_last,
    output logic                           pix_ready,
    input  logic [7:0]                     threshold,
    output logic [IMG_DIM*IMG_DIM-1:0]     image_out,
    output logic                           tpu_ena,
    input  logic                           tpu_done,
    input  logic [3:0]                     tpu_num,
    output logic [3:0]                     result,
    output logic                           result_valid,
    output logic                           frame_err,
    output logic                           busy
);

    import tpu_pkg::*;

    localparam int                 c_PIX      = IMG_DIM * IMG_DIM;
    localparam int                 c_IDX_W    = $clog2(c_PIX);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_PIX - 1);
    localparam int                 c_WD_W     = 17;

    loader_state_e      state_q;
    logic [c_IDX_W-1:0] idx_q;
    logic [c_PIX-1:0]   image_q;
    logic               tpu_ena_q;
    logic               busy_q;
    digit_t             result_q;
    logic               result_valid_q;
    logic               frame_err_q;

    logic               w_at_end;
    logic               w_expired;

    assign w_at_end = (idx_q == c_LAST_IDX);

    frame_watchdog #(
        .WIDTH (c_WD_W),
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (iRst),
        .load_i     (1'b0),
        .load_val_i ({c_WD_W{1'b0}}),
        .clr_i      (state_q != RUN),
        .cnt_en_i   (state_q == RUN),
        .expired_o  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q        <= LOAD;
            idx_q          <= '0;
            image_q        <= '0;
            tpu_ena_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (pix_valid) begin
                        // pix_last must coincide exactly with the final pixel slot
                        if (w_at_end != pix_last) begin
                            frame_err_q <= 1'b1;
                            idx_q       <= '0;
                        end else begin
                            image_q[idx_q] <= (pix_data >= threshold);
                            if (pix_last) begin
                                state_q   <= RUN;
                                idx_q     <= '0;
                                tpu_ena_q <= 1'b1;
                                busy_q    <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (tpu_done) begin
                        result_q       <= tpu_num;
                        result_valid_q <= 1'b1;
                        state_q        <= LOAD;
                        tpu_ena_q      <= 1'b0;
                        busy_q         <= 1'b0;
                    end else if (w_expired) begin
                        frame_err_q <= 1'b1;
                        state_q     <= LOAD;
                        tpu_ena_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign pix_ready    = (state_q == LOAD);
    assign image_out    = image_q;
    assign tpu_ena      = tpu_ena_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_image_frame_loader.sv
// ============================================================================
// Module : tb_image_frame_loader
// Randomised scoreboard bench for image_frame_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_image_frame_loader;

    localparam int TO   = 16;
    localparam int NPIX = 1024;

    logic            clk = 1'b0;
    logic            iRst;
    logic [7:0]      pix_data;
    logic            pix_valid;
    logic            pix_last;
    logic            pix_ready;
    logic [7:0]      threshold;
    logic [NPIX-1:0] image_out;
    logic            tpu_ena;
    logic            tpu_done;
    logic [3:0]      tpu_num;
    logic [3:0]      result;
    logic            result_valid;
    logic            frame_err;
    logic            busy;

    always #5 clk = ~clk;

    image_frame_loader #(
        .IMG_DIM (32),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .iRst         (iRst),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_last     (pix_last),
        .pix_ready    (pix_ready),
        .threshold    (threshold),
        .image_out    (image_out),
        .tpu_ena      (tpu_ena),
        .tpu_done     (tpu_done),
        .tpu_num      (tpu_num),
        .result       (result),
        .result_valid (result_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    typedef enum int {K_IMG = 0, K_RES = 1, K_ERR = 2} kind_e;
    typedef struct {
        kind_e           kind;
        logic [NPIX-1:0] img;
        logic [3:0]      res;
    } exp_t;

    exp_t            sb[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [NPIX-1:0] m_img = '0;
    logic [3:0]      m_res = '0;
    logic            prev_ena = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_img(input string name, input logic [NPIX-1:0] act, input logic [NPIX-1:0] expv);
        int k;
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            k = -1;
            for (int i = 0; i < NPIX; i++) begin
                if (act[i] !== expv[i]) begin
                    k = i;
                    break;
                end
            end
            $display("FAIL %s: bit %0d got %b expected %b", name, k, act[k], expv[k]);
        end
    endtask

    task automatic pop_check(input kind_e k);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: event kind %0d got, none expected", k);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 32'(k), 32'(e.kind));
            if (k == e.kind) begin
                if (k == K_IMG) chk_img("sb_image", image_out, e.img);
                else            chk("sb_result", 32'(result), 32'(e.res));
            end
        end
    endtask

    // Monitor: every visible DUT event must match the next expectation
    always @(negedge clk) begin
        if (!iRst) begin
            if (tpu_ena && !prev_ena) pop_check(K_IMG);
            if (result_valid)         pop_check(K_RES);
            if (frame_err)            pop_check(K_ERR);
        end
        prev_ena = tpu_ena;
    end

    task automatic check_reset();
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_tpu_ena", 32'(tpu_ena), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk_img("rst_image", image_out, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        iRst      = 1'b1;
        pix_valid = 1'b0;
        tpu_done  = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset();
        iRst  = 1'b0;
        m_res = '0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic [7:0] t, input bit last,
                              input int gap_pct, output bit ok);
        int guard = 0;
        ok = 1'b0;
        forever begin
            @(negedge clk);
            tpu_done = (gap_pct > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            tpu_num  = 4'($urandom);
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                pix_valid = 1'b0;
                pix_data  = 8'($urandom);
                pix_last  = 1'($urandom_range(0, 1));
            end else begin
                pix_valid = 1'b1;
                pix_data  = d;
                threshold = t;
                pix_last  = last;
                if (pix_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            guard++;
            if (guard > 500) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pix_ready_wait: got 0 for %0d cycles expected 1", guard);
                break;
            end
        end
    endtask

    // mode 0: full frame, 1: pix_last at index k, 2: 1024 pixels without pix_last, 3: k pixels only
    task automatic send_frame(input int mode, input int k, input int gap_pct, input bit pattern);
        logic [NPIX-1:0] fimg = '0;
        logic [7:0]      d, t;
        bit              last, ok;
        int              len;
        len = (mode == 0 || mode == 2) ? NPIX : (mode == 1) ? k + 1 : k;
        for (int i = 0; i < len; i++) begin
            d    = pattern ? ((i % 2 == 0) ? 8'd200 : 8'd10) : 8'($urandom);
            t    = pattern ? 8'd128 : 8'($urandom);
            last = (mode == 0 && i == NPIX - 1) || (mode == 1 && i == k);
            send_pixel(d, t, last, gap_pct, ok);
            if (!ok) return;
            fimg[i] = (d >= t);
        end
        if (mode == 0) begin
            sb.push_back('{K_IMG, fimg, m_res});
            m_img = fimg;
        end else if (mode != 3) begin
            sb.push_back('{K_ERR, '0, m_res});
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        tpu_done  = 1'b0;
        if (mode == 0) begin
            chk("run_ena_latency", 32'(tpu_ena), 32'd1);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_pix_ready", 32'(pix_ready), 32'd0);
        end else if (mode != 3) begin
            chk("err_stays_load_ena", 32'(tpu_ena), 32'd0);
            chk("err_stays_load_ready", 32'(pix_ready), 32'd1);
        end
    endtask

    // Called at the falling edge of the first RUN cycle; done_cycle 0 means never
    task automatic run_phase(input int done_cycle, input logic [3:0] num, input bit hold_valid,
                             input int rst_at);
        int c = 1;
        int exp_cycles;
        exp_cycles = (done_cycle >= 1 && done_cycle <= TO) ? done_cycle : TO;
        if (rst_at == 0) begin
            if (done_cycle >= 1 && done_cycle <= TO) begin
                sb.push_back('{K_RES, '0, num});
                m_res = num;
            end else begin
                sb.push_back('{K_ERR, '0, m_res});
            end
        end
        while (tpu_ena) begin
            if (c > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL run_exit_wait: got tpu_ena=1 after %0d cycles expected 0", c);
                break;
            end
            if (rst_at != 0 && c == rst_at) begin
                do_reset();
                return;
            end
            chk_img("run_image_frozen", image_out, m_img);
            chk("run_no_ready", 32'(pix_ready), 32'd0);
            tpu_done = (done_cycle != 0) && (c >= done_cycle);
            tpu_num  = tpu_done ? num : 4'($urandom);
            if (hold_valid) begin
                pix_valid = 1'b1;
                pix_data  = 8'($urandom);
                pix_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            c++;
        end
        tpu_done  = 1'b0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        chk("run_cycles", 32'(c - 1), 32'(exp_cycles));
        chk("exit_pix_ready", 32'(pix_ready), 32'd1);
        chk("exit_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        iRst      = 1'b1;
        pix_data  = '0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        threshold = '0;
        tpu_done  = 1'b0;
        tpu_num   = '0;
        repeat (3) @(negedge clk);
        check_reset();
        iRst = 1'b0;

        send_frame(0, 0, 0, 1'b1);
        run_phase(3, 4'd7, 1'b0, 0);

        send_frame(1, 500, 0, 1'b0);
        send_frame(0, 0, 20, 1'b0);
        run_phase(5, 4'($urandom), 1'b0, 0);

        send_frame(2, 0, 0, 1'b0);
        send_frame(0, 0, 0, 1'b0);
        run_phase(0, 4'd0, 1'b0, 0);

        send_frame(0, 0, 10, 1'b0);
        run_phase(TO, 4'd9, 1'b0, 0);

        send_frame(0, 0, 30, 1'b0);
        run_phase(2, 4'($urandom), 1'b1, 0);

        send_frame(3, 300, 0, 1'b0);
        do_reset();
        send_frame(0, 0, 0, 1'b0);
        run_phase(4, 4'($urandom), 1'b0, 0);

        send_frame(0, 0, 0, 1'b0);
        run_phase(0, 4'd0, 1'b0, 3);
        send_frame(0, 0, 5, 1'b0);
        run_phase(1, 4'($urandom), 1'b0, 0);

        for (int f = 0; f < 3; f++) begin
            send_frame(0, 0, int'($urandom_range(0, 40)), 1'b0);
            run_phase(int'($urandom_range(1, TO + 2)), 4'($urandom),
                      1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
